// File: rtl/blueintegral_mat_pkg.sv
// Shared opcodes, state encoding and result packing for the 2x2 binary
// matrix multiply sequencer.
package blueintegral_mat_pkg;

  localparam logic [1:0] CMD_LOAD_A    = 2'b00;
  localparam logic [1:0] CMD_LOAD_B_GO = 2'b01;
  localparam logic [1:0] CMD_CLEAR     = 2'b10;
  localparam logic [1:0] CMD_STATUS    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HAVE_A  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // LSB offsets of each 2-bit product entry inside the 8-bit result
  localparam int C00_LSB = 6;
  localparam int C01_LSB = 4;
  localparam int C10_LSB = 2;
  localparam int C11_LSB = 0;

  function automatic logic [1:0] dot2(input logic x0, input logic y0,
                                      input logic x1, input logic y1);
    return {1'b0, x0 & y0} + {1'b0, x1 & y1};
  endfunction

endpackage

// File: rtl/blueintegral_mat_core.sv
// Combinational 2x2 binary matrix product. Operand nibble is
// {m00,m01,m10,m11}; result entries are 2-bit sums (max 2).
module blueintegral_mat_core
  import blueintegral_mat_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] c
);

  logic a00, a01, a10, a11;
  logic b00, b01, b10, b11;

  assign {a00, a01, a10, a11} = a;
  assign {b00, b01, b10, b11} = b;

  assign c[C00_LSB +: 2] = dot2(a00, b00, a01, b10);
  assign c[C01_LSB +: 2] = dot2(a00, b01, a01, b11);
  assign c[C10_LSB +: 2] = dot2(a10, b00, a11, b10);
  assign c[C11_LSB +: 2] = dot2(a10, b01, a11, b11);

endmodule

// File: rtl/blueintegral_mat_seq.sv
// Command sequencer around the 2x2 binary matrix multiply core.
// state      | meaning
// ST_IDLE    | no A held, accepting commands
// ST_HAVE_A  | A held, accepting commands
// ST_COMPUTE | one cycle: register core product
// ST_HOLD    | result presented until out_ready
module blueintegral_mat_seq
  import blueintegral_mat_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_cmd,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_tag,
  output logic [7:0] out_data,
  output logic       err,
  output logic       a_held
);

  state_t             state;
  logic [3:0]         a_reg;
  logic [3:0]         b_reg;
  logic [CNT_W-1:0]   count;
  logic [7:0]         product;

  blueintegral_mat_core u_core (
    .a (a_reg),
    .b (b_reg),
    .c (product)
  );

  assign in_ready  = (state == ST_IDLE) || (state == ST_HAVE_A);
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_reg    <= 4'd0;
      b_reg    <= 4'd0;
      count    <= '0;
      out_tag  <= 1'b0;
      out_data <= 8'd0;
      err      <= 1'b0;
      a_held   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HAVE_A: begin
          if (in_valid) begin
            case (in_cmd)
              CMD_LOAD_A: begin
                a_reg  <= in_data;
                a_held <= 1'b1;
                state  <= ST_HAVE_A;
              end
              CMD_LOAD_B_GO: begin
                // a_held mirrors ST_HAVE_A while commands are accepted
                if (a_held) begin
                  b_reg <= in_data;
                  state <= ST_COMPUTE;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_CLEAR: begin
                a_held <= 1'b0;
                err    <= 1'b0;
                state  <= ST_IDLE;
              end
              default: begin
                out_data <= 8'(count);
                out_tag  <= 1'b1;
                state    <= ST_HOLD;
              end
            endcase
          end
        end
        ST_COMPUTE: begin
          out_data <= product;
          out_tag  <= 1'b0;
          count    <= count + CNT_W'(1);
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) state <= a_held ? ST_HAVE_A : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blueintegral_mat_seq.sv
// Directed plus randomized checks of blueintegral_mat_seq against a
// matrix-arithmetic reference model.
module tb_blueintegral_mat_seq;

  localparam logic [1:0] C_LA = 2'b00, C_LB = 2'b01, C_CL = 2'b10, C_ST = 2'b11;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_tag, err, a_held;
  logic [1:0] in_cmd;
  logic [3:0] in_data;
  logic [7:0] out_data;

  int tests = 0;
  int failed = 0;

  logic [3:0] m_a;
  logic       m_held, m_err;
  int         m_count;

  blueintegral_mat_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .err(err), .a_held(a_held)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mat_mul(input logic [3:0] a, input logic [3:0] b);
    int ma[2][2];
    int mb[2][2];
    int s;
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = int'(a[3-(2*i+j)]);
        mb[i][j] = int'(b[3-(2*i+j)]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += ma[i][k] * mb[k][j];
        r[7-2*(2*i+j) -: 2] = s[1:0];
      end
    return r;
  endfunction

  task automatic model_reset();
    m_a = 4'd0; m_held = 1'b0; m_err = 1'b0; m_count = 0;
  endtask

  task automatic model(input logic [1:0] cmd, input logic [3:0] data,
                       output bit has, output logic tag, output logic [7:0] dat);
    has = 1'b0; tag = 1'b0; dat = 8'd0;
    case (cmd)
      C_LA: begin m_a = data; m_held = 1'b1; end
      C_LB: begin
        if (m_held) begin
          dat = mat_mul(m_a, data); m_count = (m_count + 1) % 256; has = 1'b1;
        end else m_err = 1'b1;
      end
      C_CL: begin m_held = 1'b0; m_err = 1'b0; end
      default: begin dat = 8'(m_count); tag = 1'b1; has = 1'b1; end
    endcase
  endtask

  // Returns #1 after the accepting edge
  task automatic send(input logic [1:0] cmd, input logic [3:0] data);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    in_valid = 1'b1; in_cmd = cmd; in_data = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic etag, input logic [7:0] edat,
                            input int stall);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_tag"}, 32'(out_tag), 32'(etag));
    check({tag, "_data"}, 32'(out_data), 32'(edat));
    if (stall > 0) begin
      in_valid = 1'b1; in_cmd = C_LA; in_data = 4'hF;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, "_stall_ready"}, 32'(in_ready), 0);
        check({tag, "_stall_data"}, 32'(out_data), 32'(edat));
        check({tag, "_stall_valid"}, 32'(out_valid), 1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] cmd, input logic [3:0] data,
                        input int stall);
    bit has;
    logic etag;
    logic [7:0] edat;
    send(cmd, data);
    model(cmd, data, has, etag, edat);
    if (has) get_result(tag, etag, edat, stall);
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_a_held"}, 32'(a_held), 32'(m_held));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_tag"}, 32'(out_tag), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_a_held"}, 32'(a_held), 0);
  endtask

  initial begin
    bit has;
    logic etag;
    logic [7:0] edat;
    rst = 1'b1; in_valid = 1'b0; in_cmd = 2'b00; in_data = 4'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");

    // Latency of the first product
    do_cmd("la1", C_LA, 4'b1011, 0);
    send(C_LB, 4'b1101);
    model(C_LB, 4'b1101, has, etag, edat);
    @(negedge clk);
    check("lat_compute_no_valid", 32'(out_valid), 0);
    check("lat_compute_no_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 1);
    check("lat_data", 32'(out_data), 32'h56);
    check("lat_model_data", 32'(out_data), 32'(edat));
    check("lat_tag", 32'(out_tag), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("lat_valid_drop", 32'(out_valid), 0);
    check("lat_have_a_ready", 32'(in_ready), 1);
    check("lat_a_held", 32'(a_held), 1);

    // All-ones, all-zeros, status
    do_reset();
    do_cmd("laF", C_LA, 4'hF, 0);
    send(C_LB, 4'hF); model(C_LB, 4'hF, has, etag, edat);
    get_result("ones", 1'b0, 8'hAA, 0);
    send(C_LB, 4'h0); model(C_LB, 4'h0, has, etag, edat);
    get_result("zeros", 1'b0, 8'h00, 0);
    send(C_ST, 4'h0); model(C_ST, 4'h0, has, etag, edat);
    get_result("status2", 1'b1, 8'h02, 0);

    // Identity with a stalled consumer; the held LOAD_A must not be taken
    do_cmd("la_id", C_LA, 4'b1001, 0);
    send(C_LB, 4'b0110); model(C_LB, 4'b0110, has, etag, edat);
    get_result("ident", 1'b0, 8'h14, 5);
    do_cmd("after_stall", C_LB, 4'hF, 0);

    // err set by LOAD_B_GO with no A, cleared by CLEAR
    do_reset();
    send(C_LB, 4'h5); model(C_LB, 4'h5, has, etag, edat);
    check("err_set", 32'(err), 1);
    @(negedge clk);
    check("err_no_valid", 32'(out_valid), 0);
    check("err_model", 32'(err), 32'(m_err));
    do_cmd("clear", C_CL, 4'h0, 0);

    // Reset during COMPUTE
    do_cmd("rc_la", C_LA, 4'h7, 0);
    send(C_LB, 4'h3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_compute");
    do_cmd("rc_status", C_ST, 4'h0, 0);

    // Reset during HOLD
    do_cmd("rh_la", C_LA, 4'hF, 0);
    send(C_LB, 4'hF);
    @(negedge clk); @(negedge clk);
    check("rh_in_hold", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_hold");
    do_cmd("rh_status", C_ST, 4'h0, 0);

    // Randomized command stream
    for (int i = 0; i < 60; i++) begin
      logic [1:0] c;
      logic [3:0] d;
      c = 2'($urandom_range(0, 3));
      d = 4'($urandom);
      do_cmd("rand", c, d, int'($urandom_range(0, 2)));
    end

    // Counter wrap after 256 products
    do_reset();
    do_cmd("wrap_la", C_LA, 4'($urandom), 0);
    for (int i = 0; i < 256; i++) do_cmd("wrap_prod", C_LB, 4'($urandom), 0);
    send(C_ST, 4'h0); model(C_ST, 4'h0, has, etag, edat);
    get_result("wrap_status", 1'b1, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
